// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: select sequencer for a 4:1 mux.
// Steps the select lines {s0,s1} through channels 0..3. Each select is held
// SETTLE cycles before y is sampled. The four samples are assembled into a
// 4-bit frame, with a start/busy/done handshake around each scan.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous reset, active-low
//   start  - scan request, sampled only while idle
//   y      - mux output being sampled
//   s0,s1  - mux select; {s0,s1} is the channel index
//   busy   - scan in progress
//   done   - one-cycle pulse; frame has just been updated
//   frame  - frame[k] is the sample taken on channel k
//   chg    - one-cycle pulse with done when the new frame differs from the
//            previous frame
//
// Build option: define SCAN_CHANGE_EN to build the frame-change detector.
// When it is not defined, chg is tied low.
//
// All outputs are registered from the current state. They therefore trail the
// state register by one cycle, and no combinational path exists from start or
// y to any output.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned SETTLE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic       done,
  output logic [3:0] frame,
  output logic       chg
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [SETTLE_W-1:0] CNT_LAST = SETTLE_W'(SETTLE - 1);

  logic [1:0]          state, state_d;
  logic [1:0]          chan, chan_d;
  logic [SETTLE_W-1:0] cnt, cnt_d;
  logic [3:0]          shadow, shadow_d;
  logic                scanning;

  // State, channel, settle counter and shadow frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      chan   <= 2'd0;
      cnt    <= '0;
      shadow <= 4'd0;
    end else begin
      state  <= state_d;
      chan   <= chan_d;
      cnt    <= cnt_d;
      shadow <= shadow_d;
    end
  end

  // Next-state logic and scan datapath.
  always_comb begin
    state_d  = state;
    chan_d   = chan;
    cnt_d    = cnt;
    shadow_d = shadow;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          chan_d  = 2'd0;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt + SETTLE_W'(1);
        end
      end
      ST_SAMPLE: begin
        shadow_d[chan] = y;
        // The channel only wraps by leaving through DONE.
        if (chan == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          chan_d  = chan + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        chan_d  = 2'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign scanning = (state == ST_SETTLE) || (state == ST_SAMPLE);

  // Registered handshake, select and frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0    <= 1'b0;
      s1    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      frame <= 4'd0;
    end else begin
      s0   <= scanning & chan[1];
      s1   <= scanning & chan[0];
      busy <= scanning;
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        frame <= shadow;
      end
    end
  end

`ifdef SCAN_CHANGE_EN
  // Compare the new frame with the one being replaced; this is a pulse aligned with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg <= 1'b0;
    end else begin
      chg <= (state == ST_DONE) && (shadow != frame);
    end
  end
`else
  assign chg = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl (SETTLE=2).
// A behavioural 4:1 mux drives y from the bench inputs inp[3:0], selected by
// {s0,s1}.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       y;
  logic       s0, s1, busy, done, chg;
  logic [3:0] frame;
  logic [3:0] inp;

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign y = inp[{s0, s1}];

  mux_scan_ctrl #(.SETTLE(2), .SETTLE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .y     (y),
    .s0    (s0),
    .s1    (s1),
    .busy  (busy),
    .done  (done),
    .frame (frame),
    .chg   (chg)
  );

  // Pulse start for one edge, then wait for done. The returned latency is in
  // cycles after the accepting edge (-1 means no done arrived). Values seen
  // on the done cycle and on the cycle after it are also returned.
  task automatic do_scan(output int lat, output logic [3:0] fr, output logic c,
                         output logic c_next, output logic d_next);
    lat = -1; fr = 4'd0; c = 1'b0; c_next = 1'b0; d_next = 1'b0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n; fr = frame; c = chg;
        @(negedge clk);
        c_next = chg; d_next = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    lat = -1;
    rst_n = 1'b0; start = 1'b1; inp = 4'd0;
    repeat (3) @(negedge clk);
    tests++; if (s0 !== 1'b0) begin fails++; $display("FAIL reset_s0 got %b want 0", s0); end
    tests++; if (s1 !== 1'b0) begin fails++; $display("FAIL reset_s1 got %b want 0", s1); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (frame !== 4'b0000) begin fails++; $display("FAIL reset_frame got %b want 0000", frame); end
    tests++; if (chg !== 1'b0) begin fails++; $display("FAIL reset_chg got %b want 0", chg); end
    // Release with start held: the scan begins at the very next edge.
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    tests++; if (lat !== 13) begin fails++; $display("FAIL reset_release_latency got %0d want 13", lat); end
    @(negedge clk);
  endtask

  task automatic test_scan();
    logic [1:0] exp_sel;
    logic       exp_busy, exp_done;
    inp = 4'b1001;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      exp_busy = (n >= 1) && (n <= 12);
      exp_sel  = exp_busy ? 2'((n - 1) / 3) : 2'd0;
      exp_done = (n == 13);
      tests++;
      if ({s0, s1} !== exp_sel) begin
        fails++; $display("FAIL scan_sel n=%0d got %b want %b", n, {s0, s1}, exp_sel);
      end
      tests++;
      if ({busy, done} !== {exp_busy, exp_done}) begin
        fails++; $display("FAIL scan_busy_done n=%0d got %b want %b", n, {busy, done}, {exp_busy, exp_done});
      end
      if (n == 13) begin
        tests++;
        if (frame !== 4'b1001) begin fails++; $display("FAIL scan_frame got %b want 1001", frame); end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, first;
    ndone = 0; first = -1;
    inp = 4'b0110;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 8) start = 1'b1;   // lands on channel 2
      if (n == 9) start = 1'b0;
      if (done) begin
        ndone++;
        if (first < 0) first = n;
      end
    end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL busy_start_done_count got %0d want 1", ndone); end
    tests++; if (first !== 13) begin fails++; $display("FAIL busy_start_latency got %0d want 13", first); end
    tests++; if (frame !== 4'b0110) begin fails++; $display("FAIL busy_start_frame got %b want 0110", frame); end
  endtask

  task automatic test_reset_mid_scan();
    int ndone, lat;
    logic [3:0] fr;
    logic c, cn, dn;
    ndone = 0;
    inp = 4'b1111;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if ({s0, s1} !== 2'b10) begin fails++; $display("FAIL midrst_sel got %b want 10", {s0, s1}); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({s0, s1, busy, done, chg, frame} !== 9'd0) begin
      fails++; $display("FAIL midrst_outputs got %b want 000000000", {s0, s1, busy, done, chg, frame});
    end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    tests++; if (ndone !== 0) begin fails++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
    inp = 4'b0101;
    do_scan(lat, fr, c, cn, dn);
    tests++; if (lat !== 13) begin fails++; $display("FAIL midrst_rescan_latency got %0d want 13", lat); end
    tests++; if (fr !== 4'b0101) begin fails++; $display("FAIL midrst_rescan_frame got %b want 0101", fr); end
  endtask

  task automatic test_change();
    int lat;
    logic [3:0] fr;
    logic c, cn, dn;
`ifdef SCAN_CHANGE_EN
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    inp = 4'b0101;
    do_scan(lat, fr, c, cn, dn);
    tests++; if (c !== 1'b1) begin fails++; $display("FAIL chg_first got %b want 1", c); end
    tests++; if ({cn, dn} !== 2'b00) begin fails++; $display("FAIL chg_pulse_width got %b want 00", {cn, dn}); end
    do_scan(lat, fr, c, cn, dn);
    tests++; if (c !== 1'b0) begin fails++; $display("FAIL chg_same got %b want 0", c); end
    inp = 4'b1101;
    do_scan(lat, fr, c, cn, dn);
    tests++; if (fr !== 4'b1101) begin fails++; $display("FAIL chg_flip_frame got %b want 1101", fr); end
    tests++; if (c !== 1'b1) begin fails++; $display("FAIL chg_flip got %b want 1", c); end
`else
    inp = 4'b1010;
    do_scan(lat, fr, c, cn, dn);
    tests++; if (fr !== 4'b1010) begin fails++; $display("FAIL nochg_frame got %b want 1010", fr); end
    tests++; if ({c, cn} !== 2'b00) begin fails++; $display("FAIL nochg_chg got %b want 00", {c, cn}); end
`endif
  endtask

  task automatic test_back_to_back();
    int t_done[$];
    int lowcnt, overlap, extra;
    lowcnt = 0; overlap = 0; extra = -1;
    inp = 4'b0011;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) t_done.push_back(c);
      if (done && busy) overlap++;
      if (c >= 13 && c <= 26 && !busy) lowcnt++;
    end
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done && busy) overlap++;
      if (done) begin extra = n; break; end
    end
    tests++;
    if (t_done.size() !== 2) begin
      fails++; $display("FAIL b2b_done_count got %0d want 2", t_done.size());
    end else begin
      tests++;
      if (t_done[0] !== 13) begin fails++; $display("FAIL b2b_first_done got %0d want 13", t_done[0]); end
      tests++;
      if (t_done[1] - t_done[0] !== 14) begin
        fails++; $display("FAIL b2b_spacing got %0d want 14", t_done[1] - t_done[0]);
      end
    end
    tests++; if (lowcnt !== 2) begin fails++; $display("FAIL b2b_busy_gap got %0d want 2", lowcnt); end
    tests++; if (overlap !== 0) begin fails++; $display("FAIL b2b_busy_done_overlap got %0d want 0", overlap); end
    tests++; if (extra !== 2) begin fails++; $display("FAIL b2b_third_done got %0d want 2", extra); end
    tests++; if (frame !== 4'b0011) begin fails++; $display("FAIL b2b_frame got %b want 0011", frame); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_start_while_busy();
    test_reset_mid_scan();
    test_change();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
